ext_hamming_encoder: RTL and testbench

//  Streaming extended-Hamming (SECDED) encoder; consumes the generator rows produced by the generator-matrix stage.

---
 rtl/ext_hamming_encoder.sv | 165 ++++++++++++++++
 tb/tb_ext_hamming_encoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ext_hamming_encoder.sv
// ext_hamming_encoder
//   Streaming extended-Hamming (SECDED) encoder. Generator rows are written
//   into a small row store, then a code order m is committed, which sets the
//   message length k = 2^m - m - 1. Each accepted k-bit message is encoded
//   row-serially, one generator row per cycle, into a (k+m+1)-bit codeword
//   that is presented on a valid/ready output.
//
//   Optional build macro:
//     ROW_CHECK_EN - every accepted row write with odd weight sets cfg_err
//                    (the row is still stored).
//
// Ports
//   clk, reset              clock (rising edge), async active-high reset
//   g_wr_en/addr/data       generator row write port
//   cfg_m, cfg_commit       code order and its commit strobe
//   cfg_err                 sticky configuration error
//   cfg_k                   active message length (0 until a legal commit)
//   in_valid/ready/data     message input handshake
//   out_valid/ready/data    codeword output handshake
module ext_hamming_encoder #(
  parameter int MAX_M = 4,
  parameter int K_MAX = (1 << MAX_M) - MAX_M - 1,
  parameter int CW_W  = (1 << MAX_M)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             g_wr_en,
  input  logic [3:0]       g_wr_addr,
  input  logic [CW_W-1:0]  g_wr_data,
  input  logic [3:0]       cfg_m,
  input  logic             cfg_commit,
  output logic             cfg_err,
  output logic [4:0]       cfg_k,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [K_MAX-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW_W-1:0]  out_data
);

  localparam int IDX_W = $clog2(K_MAX);

  typedef enum logic [1:0] {UNCFG, IDLE, ENC, OUT} state_t;

  state_t           state;
  logic [CW_W-1:0]  rows [K_MAX];
  logic [3:0]       m_reg;
  logic [K_MAX-1:0] msg;
  logic [IDX_W-1:0] idx;
  logic [CW_W-1:0]  acc;

  logic             cfg_state;
  logic             wr_ok;
  logic             row_odd;
  logic             m_legal;
  logic [5:0]       pow_m;
  logic [4:0]       k_new;
  logic [4:0]       cw_len;
  logic [K_MAX-1:0] k_mask;
  logic [CW_W-1:0]  cw_mask;
  logic [CW_W-1:0]  acc_next;
  logic             last;

  // Row store and configuration only change while no message is in flight.
  assign cfg_state = (state == UNCFG) || (state == IDLE);
  assign wr_ok     = g_wr_en && cfg_state && (int'(g_wr_addr) < K_MAX);

`ifdef ROW_CHECK_EN
  assign row_odd = ^g_wr_data;
`else
  assign row_odd = 1'b0;
`endif

  assign m_legal = (cfg_m >= 4'd2) && (int'(cfg_m) <= MAX_M);
  assign pow_m   = 6'd1 << cfg_m;
  assign k_new   = 5'(pow_m - {2'b00, cfg_m} - 6'd1);
  assign cw_len  = cfg_k + {1'b0, m_reg} + 5'd1;

  // A row write in IDLE invalidates the configuration in the same cycle, so
  // the input handshake must already be refused.
  assign in_ready = (state == IDLE) && !g_wr_en;

  always_comb begin
    k_mask  = '0;
    cw_mask = '0;
    for (int i = 0; i < K_MAX; i++) k_mask[i] = (5'(i) < cfg_k);
    for (int i = 0; i < CW_W; i++) cw_mask[i] = (5'(i) < cw_len);
  end

  assign acc_next = acc ^ (msg[idx] ? rows[idx] : '0);
  assign last     = ({1'b0, 4'(idx)} == (cfg_k - 5'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < K_MAX; i++) rows[i] <= '0;
    end else if (wr_ok) begin
      rows[g_wr_addr] <= g_wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= UNCFG;
      cfg_err   <= 1'b0;
      cfg_k     <= '0;
      m_reg     <= '0;
      msg       <= '0;
      idx       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (wr_ok && row_odd) cfg_err <= 1'b1;

      case (state)
        UNCFG, IDLE: begin
          if (in_valid && in_ready) begin
            // An accepted message wins; a same-cycle commit is dropped.
            msg   <= in_data & k_mask;
            acc   <= '0;
            idx   <= '0;
            state <= ENC;
          end else begin
            if (state == IDLE && g_wr_en) begin
              state <= UNCFG;
              cfg_k <= '0;
            end
            if (cfg_commit) begin
              if (m_legal) begin
                m_reg <= cfg_m;
                cfg_k <= k_new;
                state <= IDLE;
              end else begin
                cfg_err <= 1'b1;
                state   <= UNCFG;
              end
            end
          end
        end

        ENC: begin
          acc <= acc_next;
          idx <= idx + 1'b1;
          if (last) begin
            out_data  <= acc_next & cw_mask;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end

        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            state     <= IDLE;
          end
        end

        default: state <= UNCFG;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_hamming_encoder.sv
module tb_ext_hamming_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        g_wr_en;
  logic [3:0]  g_wr_addr;
  logic [15:0] g_wr_data;
  logic [3:0]  cfg_m;
  logic        cfg_commit;
  logic        cfg_err;
  logic [4:0]  cfg_k;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  ext_hamming_encoder dut (
    .clk        (clk),
    .reset      (reset),
    .g_wr_en    (g_wr_en),
    .g_wr_addr  (g_wr_addr),
    .g_wr_data  (g_wr_data),
    .cfg_m      (cfg_m),
    .cfg_commit (cfg_commit),
    .cfg_err    (cfg_err),
    .cfg_k      (cfg_k),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input logic [3:0] addr, input logic [15:0] data);
    g_wr_en = 1'b1; g_wr_addr = addr; g_wr_data = data;
    tick;
    g_wr_en = 1'b0;
  endtask

  task automatic commit(input logic [3:0] m);
    cfg_commit = 1'b1; cfg_m = m;
    tick;
    cfg_commit = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_in_ready"},  32'(in_ready),  32'h0);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    check_eq({tag, "_out_data"},  32'(out_data),  32'h0);
    check_eq({tag, "_cfg_k"},     32'(cfg_k),     32'h0);
    check_eq({tag, "_cfg_err"},   32'(cfg_err),   32'h0);
  endtask

  // Send one message, optionally poke the write/commit ports mid-encode,
  // wait for the codeword and check latency, value, hold and release.
  task automatic encode(input string tag, input logic [10:0] d, input logic [15:0] exp,
                        input int lat, input int hold, input bit poke_mid);
    int n;
    in_valid = 1'b1; in_data = d;
    tick;
    in_valid = 1'b0; in_data = '0;
    check_eq({tag, "_busy"}, 32'(in_ready), 32'h0);
    n = 0;
    while (!out_valid && n < 40) begin
      if (poke_mid && n == 1) begin
        g_wr_en = 1'b1; g_wr_addr = 4'd0; g_wr_data = 16'h0000;
        cfg_commit = 1'b1; cfg_m = 4'd2;
      end else begin
        g_wr_en = 1'b0; cfg_commit = 1'b0;
      end
      tick;
      n++;
    end
    g_wr_en = 1'b0; cfg_commit = 1'b0;
    check_eq({tag, "_lat"},  32'(n),        32'(lat));
    check_eq({tag, "_data"}, 32'(out_data), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      tick;
      check_eq({tag, "_hold_valid"}, 32'(out_valid), 32'h1);
      check_eq({tag, "_hold_data"},  32'(out_data),  32'(exp));
      check_eq({tag, "_hold_ready"}, 32'(in_ready),  32'h0);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check_eq({tag, "_rel_valid"}, 32'(out_valid), 32'h0);
    check_eq({tag, "_rel_ready"}, 32'(in_ready),  32'h1);
  endtask

  initial begin
    reset = 1'b1; g_wr_en = 1'b0; g_wr_addr = '0; g_wr_data = '0;
    cfg_m = '0; cfg_commit = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick; tick;
    check_zero_outputs("rst");
    reset = 1'b0;
    tick;

    // m=3 generator; row 0 carries junk above bit 7 that the output mask removes
    write_row(4'd0, 16'h03E1);
    write_row(4'd1, 16'h00D2);
    write_row(4'd2, 16'h00B4);
    write_row(4'd3, 16'h0078);
    write_row(4'd4, 16'hAAAA);
    check_eq("uncfg_ready", 32'(in_ready), 32'h0);
    commit(4'd3);
    check_eq("k3", 32'(cfg_k), 32'd4);
    check_eq("k3_err", 32'(cfg_err), 32'h0);
    check_eq("k3_ready", 32'(in_ready), 32'h1);

    encode("m3_05", 11'h005, 16'h0055, 4, 0, 1'b0);
    encode("m3_0f", 11'h00F, 16'h00FF, 4, 10, 1'b0);
    encode("m3_00", 11'h000, 16'h0000, 4, 0, 1'b0);
    encode("m3_1f", 11'h01F, 16'h00FF, 4, 0, 1'b0);
    encode("m3_poke", 11'h005, 16'h0055, 4, 0, 1'b1);
    check_eq("poke_k", 32'(cfg_k), 32'd4);
    encode("m3_after_poke", 11'h005, 16'h0055, 4, 0, 1'b0);

    // row write in IDLE refuses a same-cycle handshake and drops the config
    in_valid = 1'b1; in_data = 11'h005;
    g_wr_en = 1'b1; g_wr_addr = 4'd0; g_wr_data = 16'h03E1;
    #1;
    check_eq("wr_idle_ready_comb", 32'(in_ready), 32'h0);
    tick;
    g_wr_en = 1'b0; in_valid = 1'b0;
    check_eq("wr_idle_k", 32'(cfg_k), 32'h0);
    check_eq("wr_idle_ready", 32'(in_ready), 32'h0);
    tick; tick; tick;
    check_eq("wr_idle_no_out", 32'(out_valid), 32'h0);
    commit(4'd3);
    check_eq("recommit_k", 32'(cfg_k), 32'd4);
    encode("m3_recommit", 11'h00F, 16'h00FF, 4, 0, 1'b0);

    // illegal commits
    commit(4'd1);
    check_eq("m1_err", 32'(cfg_err), 32'h1);
    check_eq("m1_k", 32'(cfg_k), 32'd4);
    check_eq("m1_ready", 32'(in_ready), 32'h0);
    commit(4'd5);
    check_eq("m5_err", 32'(cfg_err), 32'h1);
    check_eq("m5_k", 32'(cfg_k), 32'd4);
    check_eq("m5_ready", 32'(in_ready), 32'h0);

    // m=4: full 16-bit codeword, rows 5..10 still zero from reset
    commit(4'd4);
    check_eq("k4", 32'(cfg_k), 32'd11);
    check_eq("k4_err_sticky", 32'(cfg_err), 32'h1);
    encode("m4_010", 11'h010, 16'hAAAA, 11, 0, 1'b0);
    encode("m4_011", 11'h011, 16'hA94B, 11, 0, 1'b0);

    // reset in the middle of an encode
    in_valid = 1'b1; in_data = 11'h7FF;
    tick;
    in_valid = 1'b0;
    tick;
    reset = 1'b1;
    #1;
    check_zero_outputs("rst_mid");
    tick;
    reset = 1'b0;
    tick;
    check_zero_outputs("rst_after");

    write_row(4'd5, 16'h0061);
`ifdef ROW_CHECK_EN
    check_eq("odd_row_err", 32'(cfg_err), 32'h1);
`else
    check_eq("odd_row_err", 32'(cfg_err), 32'h0);
`endif

    // m=2: k=1, 4-bit codeword
    write_row(4'd0, 16'h00FF);
    commit(4'd2);
    check_eq("k2", 32'(cfg_k), 32'd1);
    encode("m2_7ff", 11'h7FF, 16'h000F, 1, 0, 1'b0);

    // row 1 was cleared by the reset
    commit(4'd4);
    check_eq("k4_again", 32'(cfg_k), 32'd11);
    encode("m4_002", 11'h002, 16'h0000, 11, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
